reg_file_mp: RTL

//  Parametrised multi-port integer register file for the RISC-V core datapath.

---
 rtl/reg_file_mp_if.sv | 17 +
 rtl/reg_file_mp.sv | 82 ++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
// Port bundle for the multi-port register file: read ports (re/ra/rd) and write ports (we/wa/wd).
interface reg_file_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;

    modport master (output re, output ra, input rd, output we, output wa, output wd);
    modport slave  (input re, input ra, output rd, input we, input wa, input wd);
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file, NRD registered read ports and NWR write ports.
// Optional build macro REG_FILE_BYPASS_EN forwards same-edge write data to the read ports.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input logic           clk,
    input logic           rst_n,
    reg_file_mp_if.slave  bus
);
    logic [XLEN-1:0] regs_r  [NREGS];
    logic [XLEN-1:0] rd_r    [NRD];
    logic [XLEN-1:0] rdata_s [NRD];
    logic [AW-1:0]   ra_s    [NRD];
    logic [AW-1:0]   wa_s    [NWR];
    logic [XLEN-1:0] wd_s    [NWR];

    // Unpack the flat address/data buses into per-port views.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra_s[i] = bus.ra[i*AW +: AW];
        end
        for (int j = 0; j < NWR; j++) begin
            wa_s[j] = bus.wa[j*AW +: AW];
            wd_s[j] = bus.wd[j*XLEN +: XLEN];
        end
    end

    // Storage update; higher-numbered write port is applied last so it wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_r[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (bus.we[j] && !((ZERO_REG != 0) && (wa_s[j] == '0))) begin
                    regs_r[wa_s[j]] <= wd_s[j];
                end
            end
        end
    end

    // Read data selection: storage, optionally forwarded write data, zero-register override last.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rdata_s[i] = regs_r[ra_s[i]];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                rdata_s[i] = (bus.we[j] && (wa_s[j] == ra_s[i])) ? wd_s[j] : rdata_s[i];
            end
`endif
            rdata_s[i] = ((ZERO_REG != 0) && (ra_s[i] == '0)) ? '0 : rdata_s[i];
        end
    end

    // Registered read ports; a disabled port holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRD; i++) begin
                rd_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (bus.re[i]) begin
                    rd_r[i] <= rdata_s[i];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            assign bus.rd[gi*XLEN +: XLEN] = rd_r[gi];
        end
    endgenerate
endmodule
